sdram_boot_arbiter: RTL

- Owns the single byte-wide SDRAM client port and shares it between the ROM boot loader (HPS ioctl download) and the CPU/motherboard memory requester.
- Maps 16 KB download chunks into fixed SDRAM banks and paces each byte write onto the clkref slot using an ioctl_wait handshake.
- Holds the machine in reset while a ROM load is in flight.
- Supplies the ROM/unpopulated read mask to the CPU data path.

---
 rtl/sdram_boot_arbiter_pkg.sv | 41 ++++
 rtl/sdram_boot_arbiter_boot_loader_fsm.sv | 107 ++++++++++
 rtl/sdram_boot_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/sdram_boot_arbiter_pkg.sv
// Shared memory-map definitions for the boot loader and SDRAM arbiter.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package amstrad_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        WR   = 2'd2
    } ldr_state_t;

    localparam logic [8:0] BANK0_DEF = 9'h000;
    localparam logic [8:0] BANK1_DEF = 9'h100;
    localparam logic [8:0] BANK2_DEF = 9'h107;

    typedef struct packed {
        logic       hit;
        logic [8:0] bank;
    } bank_map_t;

    // Map a 16 KB download chunk number onto its SDRAM bank; chunks past 2 are unmapped.
    function automatic bank_map_t chunk_to_bank(input logic [10:0] chunk,
                                                input logic [8:0]  b0,
                                                input logic [8:0]  b1,
                                                input logic [8:0]  b2);
        bank_map_t m;
        m.hit  = 1'b1;
        m.bank = b0;
        case (chunk)
            11'd0:   m.bank = b0;
            11'd1:   m.bank = b1;
            11'd2:   m.bank = b2;
            default: begin
                m.hit  = 1'b0;
                m.bank = '0;
            end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sdram_boot_arbiter_boot_loader_fsm.sv
// Boot loader: latches one ROM download byte and writes it into its mapped SDRAM bank.
// Latency: ioctl_wait rises one cycle after the strobe; write occupies the slot after the next clkref.
// Backpressure: ioctl_wait held high until the write slot closes; strobes while busy are dropped and flagged.
module boot_loader_fsm
    import amstrad_mem_pkg::*;
#(
    parameter int         ADDR_W = 23,
    parameter logic [8:0] BANK0  = BANK0_DEF,
    parameter logic [8:0] BANK1  = BANK1_DEF,
    parameter logic [8:0] BANK2  = BANK2_DEF
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              clkref,
    input  logic              rom_dl,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic              ldr_we,
    output logic [ADDR_W-1:0] ldr_addr,
    output logic [7:0]        ldr_din,
    output logic              ldr_idle,
    output logic              err_overrun,
    output logic [7:0]        drop_cnt
);

    ldr_state_t        state, state_nxt;
    logic              we_nxt, wait_nxt, err_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [7:0]        din_nxt, drop_nxt;
    bank_map_t         map;

    assign ldr_idle = (state == IDLE);

    // State and datapath registers; an async reset discards any in-flight byte.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ldr_we      <= 1'b0;
            ldr_addr    <= '0;
            ldr_din     <= '0;
            ioctl_wait  <= 1'b0;
            err_overrun <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            ldr_we      <= we_nxt;
            ldr_addr    <= addr_nxt;
            ldr_din     <= din_nxt;
            ioctl_wait  <= wait_nxt;
            err_overrun <= err_nxt;
            drop_cnt    <= drop_nxt;
        end
    end

    // Next-state: accept/drop in IDLE, then one clkref to arm and one clkref to finish the write.
    always_comb begin
        state_nxt = state;
        we_nxt    = ldr_we;
        addr_nxt  = ldr_addr;
        din_nxt   = ldr_din;
        wait_nxt  = ioctl_wait;
        err_nxt   = err_overrun;
        drop_nxt  = drop_cnt;
        map       = chunk_to_bank(ioctl_addr[24:14], BANK0, BANK1, BANK2);

        case (state)
            IDLE: begin
                if (ioctl_wr && rom_dl) begin
                    if (map.hit) begin
                        addr_nxt  = ADDR_W'({map.bank, ioctl_addr[13:0]});
                        din_nxt   = ioctl_dout;
                        wait_nxt  = 1'b1;
                        state_nxt = PEND;
                    end else if (drop_cnt != 8'hFF) begin
                        drop_nxt = drop_cnt + 8'd1;
                    end
                end
            end
            PEND: begin
                if (clkref) begin
                    we_nxt    = 1'b1;
                    state_nxt = WR;
                end
            end
            WR: begin
                if (clkref) begin
                    we_nxt    = 1'b0;
                    wait_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                we_nxt    = 1'b0;
                wait_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase

        // A strobe while a byte is still in flight is lost; remember that it happened.
        if (ioctl_wr && (state != IDLE)) begin
            err_nxt = 1'b1;
        end
    end

endmodule

// File: rtl/sdram_boot_arbiter.sv
// Shares the byte-wide SDRAM port between the ROM boot loader and the CPU; holds the machine in reset during ROM load.
// Latency: CPU path is combinational; loader writes land one to two clkref slots after the strobe.
// Backpressure: loader paced by ioctl_wait; CPU requests are ignored (CPU in reset) while the loader owns the port.
module sdram_boot_arbiter
    import amstrad_mem_pkg::*;
#(
    parameter int         ADDR_W    = 23,
    parameter logic [8:0] BANK0     = 9'h000,
    parameter logic [8:0] BANK1     = 9'h100,
    parameter logic [8:0] BANK2     = 9'h107,
    parameter logic [7:0] ROM_INDEX = 8'd0
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              clkref,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    input  logic              cpu_r,
    input  logic              cpu_w,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [7:0]        cpu_din,
    output logic              mem_oe,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic [7:0]        rom_mask,
    output logic              hold_reset,
    output logic              err_overrun,
    output logic [7:0]        drop_cnt
);

    logic              rom_dl;
    logic              sel_boot;
    logic              ldr_we, ldr_idle;
    logic [ADDR_W-1:0] ldr_addr;
    logic [7:0]        ldr_din;
    logic [8:0]        cpu_bank;
    bank_map_t         rom_map1, rom_map2;

    assign rom_dl = ioctl_download && (ioctl_index == ROM_INDEX);

    boot_loader_fsm #(
        .ADDR_W (ADDR_W),
        .BANK0  (BANK0),
        .BANK1  (BANK1),
        .BANK2  (BANK2)
    ) u_loader (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .clkref      (clkref),
        .rom_dl      (rom_dl),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .ioctl_wait  (ioctl_wait),
        .ldr_we      (ldr_we),
        .ldr_addr    (ldr_addr),
        .ldr_din     (ldr_din),
        .ldr_idle    (ldr_idle),
        .err_overrun (err_overrun),
        .drop_cnt    (drop_cnt)
    );

    // Reset request: asserted while a ROM load is active, released on a slot boundary once the loader drains.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hold_reset <= 1'b0;
        end else if (rom_dl) begin
            hold_reset <= 1'b1;
        end else if (clkref && ldr_idle) begin
            hold_reset <= 1'b0;
        end
    end

    assign sel_boot = hold_reset;

    // Port mux: loader owns the SDRAM while the machine is held in reset, otherwise the CPU passes straight through.
    always_comb begin
        mem_oe   = cpu_r;
        mem_we   = cpu_w;
        mem_addr = cpu_a;
        mem_din  = cpu_din;
        if (sel_boot) begin
            mem_oe   = 1'b0;
            mem_we   = ldr_we;
            mem_addr = ldr_addr;
            mem_din  = ldr_din;
        end
    end

    // ROM/low-RAM banks read as-is; anything else is unpopulated and reads back as all ones.
    always_comb begin
        cpu_bank = cpu_a[22:14];
        rom_map1 = chunk_to_bank(11'd1, BANK0, BANK1, BANK2);
        rom_map2 = chunk_to_bank(11'd2, BANK0, BANK1, BANK2);
        rom_mask = 8'hFF;
        if ((cpu_bank < 9'h100) ||
            (rom_map1.hit && (cpu_bank == rom_map1.bank)) ||
            (rom_map2.hit && (cpu_bank == rom_map2.bank))) begin
            rom_mask = 8'h00;
        end
    end

endmodule
